// File: rtl/toggle_handshake_rx.sv
// Responder side of a two-phase toggle handshake: synchronises req_tgl, captures
// req_data into a valid/ready port, acknowledges by toggling ack_tgl.
module toggle_handshake_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_tgl,
   input  logic [DATA_W-1:0] req_data,
   output logic              ack_tgl,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   input  logic              clr_overrun,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   req_s_d;
   logic                   req_seen;
   logic [0:0]             state;
   logic                   pending;
   logic                   late_tgl;

   assign req_s     = sync_q[SYNC_STAGES-1];
   assign pending   = (req_s != req_seen);
   assign out_valid = (state == HOLD);
   // A toggle edge while holding means the initiator did not wait for our ack.
   assign late_tgl  = (state == HOLD) && (req_s != req_s_d);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         req_s_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], req_tgl};
         req_s_d <= req_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         req_seen <= 1'b0;
         out_data <= '0;
         ack_tgl  <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // req_data is protocol-stable here, so it is sampled unsynchronised.
               if (pending) begin
                  out_data <= req_data;
                  req_seen <= req_s;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  ack_tgl  <= ~ack_tgl;
                  xfer_cnt <= xfer_cnt + 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Set has priority over clear so a violation is never silently lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            overrun <= 1'b0;
      else if (late_tgl)    overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
   end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: stimulus queues expected words, a
// monitor pops and compares them on every accepted handshake.
module tb_toggle_handshake_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_tgl;
   logic [7:0] req_data;
   logic       ack_tgl;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic       clr_overrun;
   logic [7:0] xfer_cnt;

   int         checks = 0;
   int         passes = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;
   logic       prev_ack;
   logic [7:0] junk;
   bit         rnd_done;

   toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_tgl     (req_tgl),
      .req_data    (req_data),
      .ack_tgl     (ack_tgl),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .xfer_cnt    (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard monitor: the word on the port at a valid&ready negedge is the
   // one the following rising edge accepts.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("word", {24'd0, out_data}, {24'd0, mon_e});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      req_data = d;
      req_tgl  = ~req_tgl;
      exp_q.push_back(d);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!out_valid && n < budget) begin tick(1); n++; end
      check("valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic wait_ack(input logic prev, input int budget);
      int n = 0;
      while (ack_tgl == prev && n < budget) begin tick(1); n++; end
      check("ack_timeout", {31'd0, ack_tgl != prev}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_tgl = 1'b0; req_data = 8'h00;
      out_ready = 1'b0; clr_overrun = 1'b0; rnd_done = 1'b0;
      tick(3);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ack",   {31'd0, ack_tgl},   32'd0);
      check("rst_data",  {24'd0, out_data},  32'd0);
      check("rst_cnt",   {24'd0, xfer_cnt},  32'd0);
      check("rst_ovr",   {31'd0, overrun},   32'd0);
      reset = 1'b0;
      tick(2);
      check("idle_valid", {31'd0, out_valid}, 32'd0);

      // Basic transfer and two-edge latency
      send(8'hA5);
      tick(2);
      check("lat_early", {31'd0, out_valid}, 32'd0);
      tick(1);
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_data",  {24'd0, out_data},  32'hA5);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("t1_valid", {31'd0, out_valid}, 32'd0);
      check("t1_ack",   {31'd0, ack_tgl},   32'd1);
      check("t1_cnt",   {24'd0, xfer_cnt},  32'd1);

      // Backpressure
      send(8'h3C);
      wait_valid(10);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_data",  {24'd0, out_data},  32'h3C);
         check("bp_ack",   {31'd0, ack_tgl},   32'd1);
      end
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(5);
      check("bp_ack_once", {31'd0, ack_tgl},  32'd0);
      check("bp_cnt",      {24'd0, xfer_cnt}, 32'd2);

      // Overrun: late toggle is still serviced afterwards
      send(8'hC3);
      wait_valid(10);
      send(8'h11);
      tick(4);
      check("ovr_set",    {31'd0, overrun},  32'd1);
      check("ovr_frozen", {24'd0, out_data}, 32'hC3);
      out_ready = 1'b1;
      wait_ack(1'b0, 20);
      wait_ack(1'b1, 20);
      out_ready = 1'b0;
      check("ovr_cnt",    {24'd0, xfer_cnt}, 32'd4);
      check("ovr_sticky", {31'd0, overrun},  32'd1);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr_clr", {31'd0, overrun}, 32'd0);

      // Clear coinciding with a new overrun event: set wins
      send(8'h22);
      wait_valid(10);
      send(8'h33);
      tick(2);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr_set_wins", {31'd0, overrun}, 32'd1);
      out_ready = 1'b1;
      wait_ack(1'b0, 20);
      wait_ack(1'b1, 20);
      out_ready = 1'b0;
      check("ovr2_cnt", {24'd0, xfer_cnt},     32'd6);
      check("ovr2_q",   exp_q.size(),          32'd0);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr2_clr", {31'd0, overrun}, 32'd0);

      // Reset during HOLD drops the word
      send(8'h77);
      wait_valid(10);
      check("mid_data", {24'd0, out_data}, 32'h77);
      reset = 1'b1; req_tgl = 1'b0;
      #1;
      check("mid_valid", {31'd0, out_valid}, 32'd0);
      check("mid_out",   {24'd0, out_data},  32'd0);
      check("mid_ack",   {31'd0, ack_tgl},   32'd0);
      check("mid_cnt",   {24'd0, xfer_cnt},  32'd0);
      junk = exp_q.pop_front();
      tick(1);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("mid_no_spurious", {31'd0, out_valid}, 32'd0);
      end

      // Counter wrap with ready tied high
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         prev_ack = ack_tgl;
         send(8'(i));
         wait_ack(prev_ack, 20);
         if (i == 254) begin
            check("wrap_cnt255", {24'd0, xfer_cnt}, 32'd255);
            check("wrap_ack255", {31'd0, ack_tgl},  32'd1);
         end
      end
      tick(2);
      out_ready = 1'b0;
      check("wrap_cnt", {24'd0, xfer_cnt}, 32'd0);
      check("wrap_ack", {31'd0, ack_tgl},  32'd0);
      check("wrap_q",   exp_q.size(),      32'd0);

      // Random stream: well-behaved initiator, random ready
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               prev_ack = ack_tgl;
               send(8'($urandom_range(0, 255)));
               wait_ack(prev_ack, 200);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b0;
      tick(2);
      check("rnd_ovr", {31'd0, overrun},  32'd0);
      check("rnd_cnt", {24'd0, xfer_cnt}, 32'd232);
      check("rnd_ack", {31'd0, ack_tgl},  32'd0);
      check("rnd_q",   exp_q.size(),      32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Responder end of the two-phase toggle handshake. The initiator side is a T-flip-flop toggle source: `req_tgl` flips once per transfer, and `req_data` is held stable alongside it. This block synchronises `req_tgl` into `clk`, captures `req_data`, presents it on a valid/ready output port and answers by toggling `ack_tgl`. It sits at the receiving side of any slow or asynchronous link in the design that is driven by a toggle-based initiator, and it also counts completed transfers and flags protocol overruns.

## Interface
- `DATA_W`, 8, width of the transferred data word
- `SYNC_STAGES`, 2, number of flops in the `req_tgl` synchroniser (minimum 2)
- `CNT_W`, 8, width of the transfer counter
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_tgl`  in  1  request toggle from the initiator; asynchronous to `clk`
- `req_data`  in  `DATA_W`  request payload; stable from before a `req_tgl` flip until the matching `ack_tgl` flip
- `ack_tgl`  out  1  acknowledge toggle; flips once per completed transfer
- `out_data`  out  `DATA_W`  captured payload
- `out_valid`  out  1  `out_data` holds an unconsumed word
- `out_ready`  in  1  downstream accepts `out_data` on a clock edge where `out_valid` is also high
- `overrun`  out  1  sticky flag: the initiator toggled again before being acknowledged
- `clr_overrun`  in  1  synchronous clear for `overrun`
- `xfer_cnt`  out  `CNT_W`  count of completed transfers, wraps

## Operation
- **Synchroniser.** `req_tgl` passes through `SYNC_STAGES` flops. The last stage is `req_s`. `req_s_d` is `req_s` delayed by one cycle.
- **Pending request.** Register `req_seen` holds the last accepted request level. A request is pending when `req_s != req_seen`.
- **FSM state IDLE** (`out_valid` = 0). If a request is pending, then on the clock edge:
  - `out_data` <= `req_data`
  - `req_seen` <= `req_s`
  - `out_valid` <= 1
  - next state is HOLD.
- **FSM state HOLD** (`out_valid` = 1). If `out_ready` is high, then on the clock edge:
  - `out_valid` <= 0
  - `ack_tgl` <= ~`ack_tgl`
  - `xfer_cnt` <= `xfer_cnt` + 1
  - next state is IDLE.
  - Otherwise the state holds and `out_data` is frozen.
- **Overrun detection.** In HOLD, `req_s != req_s_d` means a new toggle arrived before the acknowledge, which is a protocol violation. In that case `overrun` <= 1.
  - The late toggle is not discarded. If it leaves `req_s != req_seen`, it is serviced as a normal request after returning to IDLE.
  - A double toggle restores the original level and is lost; only `overrun` records it.
- **Overrun clear.** `clr_overrun` clears `overrun`. If a set and a clear occur in the same cycle, the set wins.
- **Counter width.** `xfer_cnt` wraps modulo 2^`CNT_W`: all-ones followed by one more transfer gives 0.
- **Data sampling.** `req_data` is sampled only on the IDLE capture edge and never passes through a synchroniser. Its stability is guaranteed by the protocol.

## Timing
- **Reset values.** While `reset` is high, all of the following are 0, asynchronously: `ack_tgl`, `out_data`, `out_valid`, `overrun`, `xfer_cnt`, the synchroniser flops, `req_s_d` and `req_seen`. The FSM is in IDLE.
- **Reset domain.** The initiator shares `reset`, so `req_tgl` is 0 when reset releases.
- **Request latency.** Let edge k be the first edge at which the flipped `req_tgl` is sampled. `req_s` flips at edge k+`SYNC_STAGES`-1. `out_valid` rises at edge k+`SYNC_STAGES`, which is k+2 with the default.
- **Handshake.** The handshake completes on the edge where `out_valid` and `out_ready` are both high. At that edge `out_valid` falls and `ack_tgl` flips.
- **Back-to-back.** If `out_ready` is held high, `out_valid` is high for exactly one cycle.
- **Minimum turnaround.** The earliest next capture is one edge after the return to IDLE. With `out_ready` tied high, the round trip from `req_tgl` flip to `ack_tgl` flip is `SYNC_STAGES`+1 clk cycles, plus the initiator's own `ack_tgl` synchronisation.
- **Reset mid-transfer.** If reset asserts during HOLD:
  - `out_valid` drops immediately.
  - The word is dropped and `ack_tgl` does not flip.
  - `xfer_cnt` returns to 0.
  - The initiator is reset by the same signal, so the protocol restarts cleanly.
- **Ready without valid.** `out_ready` high in IDLE has no effect.

## Test plan
- Reset with `req_tgl`=0, then release → all outputs are 0. Flip `req_tgl` to 1 with `req_data`=0xA5 → `out_valid` rises 2 edges later with `out_data`=0xA5. Pulse `out_ready` → `ack_tgl`=1 and `xfer_cnt`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles after capture of 0x3C → `out_valid` stays 1, `out_data` stays 0x3C, `ack_tgl` is unchanged. Raise `out_ready` → exactly one `ack_tgl` flip.
- Overrun: in HOLD, flip `req_tgl` once more with `req_data`=0x11 → `overrun`=1. After the first word is accepted, 0x11 is captured and acknowledged. Apply `clr_overrun` → `overrun`=0. Apply `clr_overrun` simultaneously with a new overrun event → `overrun` stays 1.
- Wrap: perform 256 transfers with `CNT_W`=8 and `out_ready` tied high → `xfer_cnt` returns to 0, and `ack_tgl` has flipped 256 times, ending at level 0.
- Reset mid-HOLD: capture 0x77, then assert `reset` for one cycle before `out_ready` → `out_valid`, `out_data`, `ack_tgl` and `xfer_cnt` are all 0 immediately. With no new toggle, no spurious `out_valid` follows.
- Random stream: a toggle initiator model with random `out_ready` over 1000 words → received data matches in order, no overrun, and `xfer_cnt` equals 1000 mod 256.
